// File: rtl/regbus_pkg.sv
// Shared types and constants for the peripheral register-bus initiator.
package regbus_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;

   // Access size encodings as presented by the CPU load/store stage.
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_ILL  = 2'd3
   } size_e;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      RD_WAIT,
      RESP
   } state_e;

   // A request is rejected without touching the bus when its size is illegal
   // or its address is not naturally aligned to that size.
   function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] off);
      case (size_e'(size))
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         SZ_WORD: return (off != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/regbus_lane_align.sv
// Byte-lane steering: store-side byte enables and data replication, and
// load-side lane extraction with sign or zero extension.
module regbus_lane_align
   import regbus_pkg::*;
(
   input  logic [1:0]        st_size,
   input  logic [1:0]        st_off,
   input  logic [DATA_W-1:0] st_data,
   output logic [3:0]        st_be,
   output logic [DATA_W-1:0] st_wdata,
   input  logic [1:0]        ld_size,
   input  logic [1:0]        ld_off,
   input  logic              ld_unsigned,
   input  logic [DATA_W-1:0] ld_rdata,
   output logic [DATA_W-1:0] ld_data
);

   logic [DATA_W-1:0] lane;
   logic signed [7:0]  lane_b;
   logic signed [15:0] lane_h;

   // Store path: enables follow the byte offset, data is replicated onto every lane.
   always_comb begin
      st_be    = 4'b0000;
      st_wdata = '0;
      case (size_e'(st_size))
         SZ_BYTE: begin
            st_be    = 4'b0001 << st_off;
            st_wdata = {4{st_data[7:0]}};
         end
         SZ_HALF: begin
            st_be    = 4'b0011 << st_off;
            st_wdata = {2{st_data[15:0]}};
         end
         SZ_WORD: begin
            st_be    = 4'b1111;
            st_wdata = st_data;
         end
         default: begin
            st_be    = 4'b0000;
            st_wdata = '0;
         end
      endcase
   end

   // Load path: shift the addressed lane down to bit 0, then extend to full width.
   always_comb begin
      lane    = ld_rdata >> {ld_off, 3'b000};
      lane_b  = signed'(lane[7:0]);
      lane_h  = signed'(lane[15:0]);
      ld_data = '0;
      case (size_e'(ld_size))
         SZ_BYTE: ld_data = ld_unsigned ? {{(DATA_W-8){1'b0}}, lane[7:0]}
                                        : DATA_W'(lane_b);
         SZ_HALF: ld_data = ld_unsigned ? {{(DATA_W-16){1'b0}}, lane[15:0]}
                                        : DATA_W'(lane_h);
         SZ_WORD: ld_data = lane;
         default: ld_data = '0;
      endcase
   end

endmodule

// File: rtl/regbus_master.sv
// Register-bus initiator: turns CPU load/store requests into single-cycle
// write/read strobes, waits for read data with a bounded timeout, and returns
// a one-cycle response. All outputs except req_ready are registered.
module regbus_master
   import regbus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15
)(
   input  logic              clk,
   input  logic              rstb,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              wr_en,
   output logic [3:0]        be,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wdata,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rdata,
   input  logic              rd_rdy
);

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

   state_e            state, state_nxt;
   logic [7:0]        cnt, cnt_nxt, cnt_inc;
   logic              err_nxt;
   logic [DATA_W-1:0] rdata_nxt;

   logic [1:0]        lat_size;
   logic [1:0]        lat_off;
   logic              lat_unsigned;

   logic [3:0]        st_be;
   logic [DATA_W-1:0] st_wdata;
   logic [DATA_W-1:0] ld_data;

   // Store lanes come straight from the request so they can be registered
   // on the accept edge; load lanes use the latched request fields.
   regbus_lane_align u_align (
      .st_size     (req_size),
      .st_off      (req_addr[1:0]),
      .st_data     (req_wdata),
      .st_be       (st_be),
      .st_wdata    (st_wdata),
      .ld_size     (lat_size),
      .ld_off      (lat_off),
      .ld_unsigned (lat_unsigned),
      .ld_rdata    (rdata),
      .ld_data     (ld_data)
   );

   assign req_ready = (state == IDLE);

   // Request latch: captures the fields the load path needs after acceptance.
   always_ff @(posedge clk) begin
      if (req_valid && req_ready) begin
         lat_size     <= req_size;
         lat_off      <= req_addr[1:0];
         lat_unsigned <= req_unsigned;
      end
   end

   // Next-state, timeout counting and response contents.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cnt_inc   = cnt + 8'd1;
      err_nxt   = 1'b0;
      rdata_nxt = '0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_is_bad(req_size, req_addr[1:0])) begin
                  state_nxt = RESP;
                  err_nxt   = 1'b1;
               end else if (req_we) begin
                  state_nxt = WRITE;
               end else begin
                  state_nxt = READ;
               end
            end
         end
         WRITE: state_nxt = RESP;
         READ: begin
            state_nxt = RD_WAIT;
            cnt_nxt   = '0;
         end
         RD_WAIT: begin
            // Read data takes priority over a timeout landing in the same cycle.
            if (rd_rdy) begin
               state_nxt = RESP;
               rdata_nxt = ld_data;
            end else if (cnt_inc == TO_LIM) begin
               state_nxt = RESP;
               err_nxt   = 1'b1;
               cnt_nxt   = cnt_inc;
            end else begin
               cnt_nxt   = cnt_inc;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register and timeout counter.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Registered bus and response outputs, driven from the state being entered.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         wr_en      <= 1'b0;
         rd_en      <= 1'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         be         <= '0;
         wr_addr    <= '0;
         wdata      <= '0;
         rd_addr    <= '0;
      end else begin
         wr_en      <= (state_nxt == WRITE);
         rd_en      <= (state_nxt == READ);
         resp_valid <= (state_nxt == RESP);
         resp_err   <= err_nxt;
         resp_rdata <= rdata_nxt;
         if (state_nxt == WRITE) begin
            be      <= st_be;
            wr_addr <= {req_addr[ADDR_W-1:2], 2'b00};
            wdata   <= st_wdata;
         end
         if (state_nxt == READ) begin
            rd_addr <= {req_addr[ADDR_W-1:2], 2'b00};
         end
      end
   end

endmodule

// File: tb/tb_regbus_master.sv
// Directed bench for regbus_master with a response scoreboard.
module tb_regbus_master;

   localparam int TO = 15;

   logic        clk;
   logic        rstb;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        wr_en;
   logic [3:0]  be;
   logic [15:0] wr_addr;
   logic [31:0] wdata;
   logic        rd_en;
   logic [15:0] rd_addr;
   logic [31:0] rdata;
   logic        rd_rdy;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks;
   int   n_errors;

   regbus_master #(.TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .rstb         (rstb),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_err     (resp_err),
      .resp_rdata   (resp_rdata),
      .wr_en        (wr_en),
      .be           (be),
      .wr_addr      (wr_addr),
      .wdata        (wdata),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .rdata        (rdata),
      .rd_rdy       (rd_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ":wr_en"},      32'(wr_en),      32'd0);
      chk({tag, ":rd_en"},      32'(rd_en),      32'd0);
      chk({tag, ":resp_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, ":resp_err"},   32'(resp_err),   32'd0);
      chk({tag, ":resp_rdata"}, resp_rdata,      32'd0);
      chk({tag, ":be"},         32'(be),         32'd0);
      chk({tag, ":wr_addr"},    32'(wr_addr),    32'd0);
      chk({tag, ":wdata"},      wdata,           32'd0);
      chk({tag, ":rd_addr"},    32'(rd_addr),    32'd0);
      chk({tag, ":req_ready"},  32'(req_ready),  32'd1);
   endtask

   // Called at #1 after a clock edge with the DUT idle; that cycle is T.
   task automatic run_req(
      input string       tag,
      input logic        we,
      input logic [1:0]  size,
      input logic        uns,
      input logic [15:0] addr,
      input logic [31:0] wd,
      input int          rdy_cyc,
      input logic [31:0] rdv,
      input int          exp_wr,
      input logic [3:0]  exp_be,
      input logic [31:0] exp_wdata,
      input int          exp_rd,
      input logic [15:0] exp_baddr,
      input logic        exp_err,
      input logic [31:0] exp_rdata,
      input int          exp_lat
   );
      exp_t        e;
      exp_t        got;
      int          cyc;
      int          nwr, nrd, both, wcyc, rcyc;
      logic [3:0]  sbe;
      logic [15:0] swa, sra;
      logic [31:0] swd, r_rdata;
      logic        r_err;
      bit          done;
      nwr = 0; nrd = 0; both = 0; wcyc = 0; rcyc = 0;
      sbe = '0; swa = '0; sra = '0; swd = '0; r_rdata = '0; r_err = 1'b0;
      chk({tag, ":ready"}, 32'(req_ready), 32'd1);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      e.err   = exp_err;
      e.rdata = exp_rdata;
      e.lat   = exp_lat;
      exp_q.push_back(e);
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         req_valid = 1'b0;
         rd_rdy    = (rdy_cyc != 0) && (cyc == rdy_cyc);
         rdata     = rdv;
         if (wr_en) begin
            nwr++; wcyc = cyc; sbe = be; swa = wr_addr; swd = wdata;
         end
         if (rd_en) begin
            nrd++; rcyc = cyc; sra = rd_addr;
         end
         if (wr_en && rd_en) both++;
         if (resp_valid) begin
            done    = 1'b1;
            r_err   = resp_err;
            r_rdata = resp_rdata;
         end
      end
      rd_rdy = 1'b0;
      chk({tag, ":resp_seen"}, 32'(done), 32'd1);
      if (done) begin
         if (exp_q.size() == 0) begin
            chk({tag, ":sb_nonempty"}, 32'd0, 32'(exp_q.size() + 1));
         end else begin
            got = exp_q.pop_front();
            chk({tag, ":resp_err"},   32'(r_err), 32'(got.err));
            chk({tag, ":resp_rdata"}, r_rdata,    got.rdata);
            chk({tag, ":latency"},    32'(cyc),   32'(got.lat));
         end
      end
      chk({tag, ":wr_pulses"}, 32'(nwr),  32'(exp_wr));
      chk({tag, ":rd_pulses"}, 32'(nrd),  32'(exp_rd));
      chk({tag, ":wr_rd_both"}, 32'(both), 32'd0);
      if (exp_wr != 0) begin
         chk({tag, ":wr_cycle"}, 32'(wcyc), 32'd1);
         chk({tag, ":be"},       32'(sbe),  32'(exp_be));
         chk({tag, ":wr_addr"},  32'(swa),  32'(exp_baddr));
         chk({tag, ":wdata"},    swd,       exp_wdata);
      end
      if (exp_rd != 0) begin
         chk({tag, ":rd_cycle"}, 32'(rcyc), 32'd1);
         chk({tag, ":rd_addr"},  32'(sra),  32'(exp_baddr));
      end
      @(posedge clk);
      #1;
      chk({tag, ":resp_drop"}, 32'(resp_valid), 32'd0);
      chk({tag, ":idle"},      32'(req_ready),  32'd1);
   endtask

   initial begin
      int seen;
      n_checks     = 0;
      n_errors     = 0;
      rstb         = 1'b0;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'd0;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      rdata        = '0;
      rd_rdy       = 1'b0;

      #12;
      chk_all_zero("reset");
      rstb = 1'b1;
      @(posedge clk);
      #1;

      //      tag        we  sz   uns  addr      wdata         rdy  rdata         wr be       wdata         rd baddr     err  rdata         lat
      run_req("st_b",    1, 2'd0, 0, 16'h0001, 32'h000000A5,  0, 32'h0,        1, 4'b0010, 32'hA5A5A5A5, 0, 16'h0000, 0, 32'h00000000, 2);
      run_req("ld_w",    0, 2'd2, 0, 16'h0000, 32'h0,         2, 32'h12345678, 0, 4'b0000, 32'h0,        1, 16'h0000, 0, 32'h12345678, 3);
      run_req("ld_bs",   0, 2'd0, 0, 16'h0003, 32'h0,         2, 32'h80000000, 0, 4'b0000, 32'h0,        1, 16'h0000, 0, 32'hFFFFFF80, 3);
      run_req("ld_bu",   0, 2'd0, 1, 16'h0003, 32'h0,         2, 32'h80000000, 0, 4'b0000, 32'h0,        1, 16'h0000, 0, 32'h00000080, 3);
      run_req("ld_hs",   0, 2'd1, 0, 16'h0002, 32'h0,         2, 32'h80011234, 0, 4'b0000, 32'h0,        1, 16'h0000, 0, 32'hFFFF8001, 3);
      run_req("ld_hu",   0, 2'd1, 1, 16'h0006, 32'h0,         2, 32'hF00D8001, 0, 4'b0000, 32'h0,        1, 16'h0004, 0, 32'h0000F00D, 3);
      run_req("st_w",    1, 2'd2, 0, 16'h0104, 32'hDEADBEEF,  0, 32'h0,        1, 4'b1111, 32'hDEADBEEF, 0, 16'h0104, 0, 32'h00000000, 2);
      run_req("st_h",    1, 2'd1, 0, 16'h0012, 32'h1234BEEF,  0, 32'h0,        1, 4'b1100, 32'hBEEFBEEF, 0, 16'h0010, 0, 32'h00000000, 2);
      run_req("st_hmis", 1, 2'd1, 0, 16'h0001, 32'h0000FFFF,  0, 32'h0,        0, 4'b0000, 32'h0,        0, 16'h0000, 1, 32'h00000000, 1);
      run_req("ld_sz3",  0, 2'd3, 0, 16'h0000, 32'h0,         2, 32'h55555555, 0, 4'b0000, 32'h0,        0, 16'h0000, 1, 32'h00000000, 1);
      run_req("ld_wmis", 0, 2'd2, 0, 16'h0002, 32'h0,         2, 32'h55555555, 0, 4'b0000, 32'h0,        0, 16'h0000, 1, 32'h00000000, 1);
      run_req("ld_late", 0, 2'd0, 0, 16'h0041, 32'h0,         5, 32'h00007F00, 0, 4'b0000, 32'h0,        1, 16'h0040, 0, 32'h0000007F, 6);
      run_req("ld_to",   0, 2'd2, 0, 16'h0080, 32'h0,         0, 32'h99999999, 0, 4'b0000, 32'h0,        1, 16'h0080, 1, 32'h00000000, TO + 2);

      // A late rd_rdy after the timeout must not produce a response.
      seen   = 0;
      rd_rdy = 1'b1;
      rdata  = 32'h77777777;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (resp_valid) seen++;
      end
      rd_rdy = 1'b0;
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
      chk("stray_rdy:resp", 32'(seen), 32'd0);

      run_req("ld_after", 0, 2'd2, 0, 16'h0010, 32'h0,        2, 32'hA1B2C3D4, 0, 4'b0000, 32'h0,        1, 16'h0010, 0, 32'hA1B2C3D4, 3);
      // rd_rdy in the last counted cycle wins over the timeout.
      run_req("ld_edge",  0, 2'd2, 0, 16'h0020, 32'h0,  TO + 1, 32'hCAFEF00D, 0, 4'b0000, 32'h0,        1, 16'h0020, 0, 32'hCAFEF00D, TO + 2);

      // Reset while waiting for read data.
      req_valid    = 1'b1;
      req_we       = 1'b0;
      req_size     = 2'd2;
      req_unsigned = 1'b0;
      req_addr     = 16'h00F0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("rst_mid:rd_en", 32'(rd_en), 32'd1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      #2;
      rstb = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      @(posedge clk);
      #1;
      rstb = 1'b1;
      seen = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (resp_valid) seen++;
      end
      chk("rst_mid:no_resp", 32'(seen), 32'd0);

      run_req("ld_post",  0, 2'd1, 0, 16'h0032, 32'h0,        2, 32'h7FFF0000, 0, 4'b0000, 32'h0,        1, 16'h0030, 0, 32'h00007FFF, 3);
      run_req("st_post",  1, 2'd0, 0, 16'h0033, 32'h0000003C, 0, 32'h0,        1, 4'b1000, 32'h3C3C3C3C, 0, 16'h0030, 0, 32'h00000000, 2);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
